// File: rtl/sseg_scan_ctrl_if.sv
// Register bus shared by the seven-segment scan controller and its host.
interface sseg_scan_ctrl_if;
   logic        chipselect;
   logic        write;
   logic        read;
   logic [3:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output chipselect, write, read, address, writedata, input readdata);
   modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scanner: per-digit slots split into 16 PWM phases,
// frame-based blink, and a small register file on a chipselect/read/write bus.
module sseg_scan_ctrl #(
   parameter int N_DIGITS     = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 250
) (
   input  logic                clk,
   input  logic                reset,
   sseg_scan_ctrl_if.slave     bus,
   output logic [N_DIGITS-1:0] an_n,
   output logic [7:0]          seg_n
);
   localparam int PRE_CNT = SCAN_DIV / 16;
   localparam int PRE_W   = (PRE_CNT > 1) ? $clog2(PRE_CNT) : 1;
   localparam int IDX_W   = $clog2(N_DIGITS);
   localparam int FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRE_CNT - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
   localparam logic [FRM_W-1:0]    FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
   localparam logic [N_DIGITS-1:0] AN_ONE   = {{(N_DIGITS-1){1'b0}}, 1'b1};

   function automatic logic [6:0] hex_decode(input logic [3:0] v);
      case (v)
         4'h0: hex_decode = 7'h40;
         4'h1: hex_decode = 7'h79;
         4'h2: hex_decode = 7'h24;
         4'h3: hex_decode = 7'h30;
         4'h4: hex_decode = 7'h19;
         4'h5: hex_decode = 7'h12;
         4'h6: hex_decode = 7'h02;
         4'h7: hex_decode = 7'h78;
         4'h8: hex_decode = 7'h00;
         4'h9: hex_decode = 7'h10;
         4'hA: hex_decode = 7'h08;
         4'hB: hex_decode = 7'h03;
         4'hC: hex_decode = 7'h46;
         4'hD: hex_decode = 7'h21;
         4'hE: hex_decode = 7'h06;
         4'hF: hex_decode = 7'h0E;
         default: hex_decode = 7'h7F;
      endcase
   endfunction

   logic [PRE_W-1:0]    presc_r;
   logic [3:0]          phase_r;
   logic [IDX_W-1:0]    idx_r;
   logic [FRM_W-1:0]    frame_r;
   logic                blink_phase_r;
   logic [7:0]          digit_r [N_DIGITS];
   logic                en_r;
   logic                hex_r;
   logic [3:0]          bright_r;
   logic [N_DIGITS-1:0] blink_mask_r;

   logic                we_s, re_s, presc_tc_s, slot_tc_s, frame_tc_s, lit_s;
   logic [7:0]          rd_val_s, cur_digit_s, seg_s;
   logic [6:0]          seg7_s;
   logic [N_DIGITS-1:0] an_s;

   // Bus strobes and scan terminal counts.
   always_comb begin
      we_s       = bus.chipselect & bus.write;
      re_s       = bus.chipselect & bus.read;
      presc_tc_s = (presc_r == PRE_LAST);
      slot_tc_s  = presc_tc_s && (phase_r == 4'd15);
      frame_tc_s = slot_tc_s && (idx_r == IDX_LAST);
   end

   // Scan counters run freely; register writes never touch them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_r       <= '0;
         phase_r       <= 4'd0;
         idx_r         <= '0;
         frame_r       <= '0;
         blink_phase_r <= 1'b0;
      end else begin
         presc_r <= presc_tc_s ? '0 : presc_r + PRE_W'(1);
         if (presc_tc_s) phase_r <= phase_r + 4'd1;
         if (slot_tc_s)  idx_r   <= frame_tc_s ? '0 : idx_r + IDX_W'(1);
         if (frame_tc_s) begin
            if (frame_r == FRM_LAST) begin
               frame_r       <= '0;
               blink_phase_r <= ~blink_phase_r;
            end else begin
               frame_r <= frame_r + FRM_W'(1);
            end
         end
      end
   end

   // Register file writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digit_r      <= '{default: 8'd0};
         en_r         <= 1'b1;
         hex_r        <= 1'b1;
         bright_r     <= 4'hF;
         blink_mask_r <= '0;
      end else if (we_s) begin
         case (bus.address)
            4'd8: begin
               en_r     <= bus.writedata[0];
               hex_r    <= bus.writedata[1];
               bright_r <= bus.writedata[7:4];
            end
            4'd9: blink_mask_r <= bus.writedata[N_DIGITS-1:0];
            default: begin
               if (bus.address < 4'(N_DIGITS)) digit_r[bus.address[IDX_W-1:0]] <= bus.writedata[7:0];
            end
         endcase
      end
   end

   // Read mux sees pre-write contents, so a same-cycle write returns old data.
   always_comb begin
      case (bus.address)
         4'd8:    rd_val_s = {bright_r, 2'b00, hex_r, en_r};
         4'd9:    rd_val_s = 8'(blink_mask_r);
         default: rd_val_s = (bus.address < 4'(N_DIGITS)) ? digit_r[bus.address[IDX_W-1:0]] : 8'd0;
      endcase
   end

   // Read data register holds until the next read strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.readdata <= 32'd0;
      end else if (re_s) begin
         bus.readdata <= {24'd0, rd_val_s};
      end
   end

   // Lit decision and segment pattern for the digit in the current slot.
   always_comb begin
      cur_digit_s = digit_r[idx_r];
      lit_s       = en_r && (phase_r <= bright_r) && !(blink_mask_r[idx_r] && blink_phase_r);
      seg7_s      = hex_r ? hex_decode(cur_digit_s[3:0]) : ~cur_digit_s[6:0];
      if (lit_s) begin
         an_s  = ~(AN_ONE << idx_r);
         seg_s = {~cur_digit_s[7], seg7_s};
      end else begin
         an_s  = '1;
         seg_s = 8'hFF;
      end
   end

   // Output register stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_n  <= '1;
         seg_n <= 8'hFF;
      end else begin
         an_n  <= an_s;
         seg_n <= seg_s;
      end
   end
endmodule
